// File: rtl/mem_arbiter.sv
// Two-port (I-side / D-side) arbiter and handshake owner for the single-port unified memory.
// Build option: define ARB_RR_EN for round-robin grant; default build is fixed D-over-I priority.

module mem_arbiter #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rdy,
    output logic [DATA_W-1:0] i_rd_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rdy,
    output logic [DATA_W-1:0] d_rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rdy,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned     CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             owner_d;      // 1: D-side owns the outstanding access
    logic             lat_we;
    logic [CNT_W-1:0] wait_cnt;

    logic             pick_d_c;
    logic             grant_c;
    logic             done_c;
    logic             tmo_c;

    logic             mem_re_nxt;
    logic             mem_we_nxt;
    logic             i_rdy_nxt;
    logic             d_rdy_nxt;
    logic             busy_nxt;

`ifdef ARB_RR_EN
    // last_d remembers whether the previous grant went to D; on collision the other side wins
    logic last_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d <= 1'b0;
        end else if (grant_c) begin
            last_d <= pick_d_c;
        end
    end

    assign pick_d_c = d_req && (!i_req || !last_d);
`else
    assign pick_d_c = d_req;
`endif

    assign grant_c = (state == S_IDLE) && (i_req || d_req);
    assign tmo_c   = (state == S_WAIT) && !mem_rdy && (wait_cnt == CNT_LAST);
    assign done_c  = (state == S_WAIT) && (mem_rdy || (wait_cnt == CNT_LAST));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (grant_c) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (done_c) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: values the output registers take on the next edge
    always_comb begin
        mem_re_nxt = 1'b0;
        mem_we_nxt = 1'b0;
        i_rdy_nxt  = 1'b0;
        d_rdy_nxt  = 1'b0;
        busy_nxt   = (state_nxt != S_IDLE);
        if (grant_c) begin
            mem_we_nxt = pick_d_c && d_we;
            mem_re_nxt = !(pick_d_c && d_we);
        end
        if (done_c) begin
            i_rdy_nxt = !owner_d;
            d_rdy_nxt = owner_d;
        end
    end

    // Output registers, request latch, wait counter and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_re      <= 1'b0;
            mem_we      <= 1'b0;
            i_rdy       <= 1'b0;
            d_rdy       <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            i_rd_data   <= '0;
            d_rd_data   <= '0;
            owner_d     <= 1'b0;
            lat_we      <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            mem_re <= mem_re_nxt;
            mem_we <= mem_we_nxt;
            i_rdy  <= i_rdy_nxt;
            d_rdy  <= d_rdy_nxt;
            busy   <= busy_nxt;

            if (grant_c) begin
                owner_d   <= pick_d_c;
                lat_we    <= pick_d_c && d_we;
                mem_addr  <= pick_d_c ? d_addr : i_addr;
                mem_wdata <= pick_d_c ? d_wdata : '0;
            end

            wait_cnt <= (state == S_WAIT) ? wait_cnt + CNT_W'(1) : '0;

            // A timed-out access returns zero data to its owner, read or write
            if (tmo_c) begin
                timeout_err <= 1'b1;
                if (owner_d) begin
                    d_rd_data <= '0;
                end else begin
                    i_rd_data <= '0;
                end
            end else if (done_c && !lat_we) begin
                if (owner_d) begin
                    d_rd_data <= mem_rd_data;
                end else begin
                    i_rd_data <= mem_rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed protocol steps plus randomized traffic against a
// transaction-level model (grant rule, latency formula, reference memory contents).

module tb_mem_arbiter;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 16;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_rdy;
    logic [DW-1:0] i_rd_data;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_rdy;
    logic [DW-1:0] d_rd_data;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rd_data;
    logic          mem_rdy;
    logic          busy;
    logic          timeout_err;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_rd_data(i_rd_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdy(d_rdy), .d_rd_data(d_rd_data),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rd_data(mem_rd_data), .mem_rdy(mem_rdy),
        .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-on memory image shared by the memory stand-in and the reference model
    function automatic logic [DW-1:0] seed_val(input logic [AW-1:0] a);
        return (a == 16'h0010) ? 32'h1234_5678 : {a, ~a};
    endfunction

    // Memory stand-in: mem_rdy pulses in the mem_lat-th cycle after the strobe
    int            mem_lat  = 4;
    bit            mem_dead = 1'b0;
    bit            pend     = 1'b0;
    int            pend_cnt = 0;
    logic [DW-1:0] rbuf;
    logic [DW-1:0] wr_store [logic [AW-1:0]];

    always @(posedge clk) begin
        mem_rdy     <= 1'b0;
        mem_rd_data <= $urandom;
        if (rst) begin
            pend = 1'b0;
        end else if (mem_re || mem_we) begin
            pend     = 1'b1;
            pend_cnt = 0;
            if (mem_we) wr_store[mem_addr] = mem_wdata;
            rbuf = wr_store.exists(mem_addr) ? wr_store[mem_addr] : seed_val(mem_addr);
        end else if (pend) begin
            pend_cnt++;
            if (!mem_dead && pend_cnt == mem_lat - 1) begin
                mem_rdy     <= 1'b1;
                mem_rd_data <= rbuf;
                pend = 1'b0;
            end
        end
    end

    // Strobe counters sampled on the falling edge
    int re_cnt   = 0;
    int we_cnt   = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (mem_re) re_cnt++;
        if (mem_we) we_cnt++;
        if (mem_re && mem_we) both_cnt++;
    end

    // Reference model state
    logic [DW-1:0] ref_store [logic [AW-1:0]];
    logic [DW-1:0] exp_i    = '0;
    logic [DW-1:0] exp_d    = '0;
    bit            exp_tmo  = 1'b0;
    bit            last_d_m = 1'b0;
    int            snap_re  = 0;
    int            snap_we  = 0;

    int total = 0;
    int bad   = 0;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_store.exists(a) ? ref_store[a] : seed_val(a);
    endfunction

    function automatic bit model_pick_d(input bit ri, input bit rq);
        if (!rq) return 1'b0;
        if (!ri) return 1'b1;
        return RR ? !last_d_m : 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        snap_re = re_cnt;
        snap_we = we_cnt;
    endtask

    task automatic wait_rdy(output int cyc, output logic gi, output logic gd);
        cyc = 0;
        gi  = 1'b0;
        gd  = 1'b0;
        while (cyc < 60 && !gi && !gd) begin
            tick();
            cyc++;
            gi = i_rdy;
            gd = d_rdy;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_re"},    64'(mem_re),      64'd0);
        chk({tag, "_mem_we"},    64'(mem_we),      64'd0);
        chk({tag, "_i_rdy"},     64'(i_rdy),       64'd0);
        chk({tag, "_d_rdy"},     64'(d_rdy),       64'd0);
        chk({tag, "_busy"},      64'(busy),        64'd0);
        chk({tag, "_tmo"},       64'(timeout_err), 64'd0);
        chk({tag, "_mem_addr"},  64'(mem_addr),    64'd0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata),   64'd0);
        chk({tag, "_i_rd_data"}, 64'(i_rd_data),   64'd0);
        chk({tag, "_d_rd_data"}, 64'(d_rd_data),   64'd0);
    endtask

    // Wait for one access to complete and compare it with the model's prediction
    task automatic serve(input bit side_d, input bit tmo, input int exp_cyc, input string tag);
        int   cyc;
        logic gi;
        logic gd;
        bit   wr;
        wr = side_d && d_we;
        if (wr) ref_store[d_addr] = d_wdata;
        wait_rdy(cyc, gi, gd);
        if (tmo) begin
            exp_tmo = 1'b1;
            if (side_d) exp_d = '0;
            else        exp_i = '0;
        end else if (!wr) begin
            if (side_d) exp_d = ref_rd(d_addr);
            else        exp_i = ref_rd(i_addr);
        end
        last_d_m = side_d;
        chk({tag, "_side"},    64'({gi, gd}),              side_d ? 64'd1 : 64'd2);
        chk({tag, "_latency"}, 64'(cyc),                   64'(exp_cyc));
        chk({tag, "_i_data"},  64'(i_rd_data),             64'(exp_i));
        chk({tag, "_d_data"},  64'(d_rd_data),             64'(exp_d));
        chk({tag, "_tmo"},     64'(timeout_err),           64'(exp_tmo));
        chk({tag, "_re_cnt"},  64'(re_cnt - snap_re),      wr ? 64'd0 : 64'd1);
        chk({tag, "_we_cnt"},  64'(we_cnt - snap_we),      wr ? 64'd1 : 64'd0);
    endtask

    initial begin
        bit   first;
        bit   ri;
        bit   rq;
        bit   seen;

        rst     = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // I-side read of 0x0010
        snap();
        i_req  = 1'b1;
        i_addr = 16'h0010;
        tick();
        chk("t1_T1_mem_re",   64'(mem_re),   64'd1);
        chk("t1_T1_mem_we",   64'(mem_we),   64'd0);
        chk("t1_T1_mem_addr", 64'(mem_addr), 64'h0010);
        chk("t1_T1_busy",     64'(busy),     64'd1);
        tick();
        chk("t1_T2_mem_re",   64'(mem_re),   64'd0);
        chk("t1_T2_mem_addr", 64'(mem_addr), 64'h0010);
        serve(1'b0, 1'b0, 4, "t1");
        chk("t1_T6_busy", 64'(busy),      64'd1);
        chk("t1_T6_data", 64'(i_rd_data), 64'h1234_5678);
        tick();
        i_req = 1'b0;
        chk("t1_T7_busy", 64'(busy), 64'd0);
        tick();

        // D-side write, request held through the cycle after d_rdy
        snap();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0200;
        d_wdata = 32'hCAFE_F00D;
        tick();
        chk("t2_T1_mem_we",    64'(mem_we),    64'd1);
        chk("t2_T1_mem_re",    64'(mem_re),    64'd0);
        chk("t2_T1_mem_addr",  64'(mem_addr),  64'h0200);
        chk("t2_T1_mem_wdata", 64'(mem_wdata), 64'hCAFE_F00D);
        serve(1'b1, 1'b0, 5, "t2");
        tick();
        d_req = 1'b0;
        repeat (3) tick();
        chk("t6_no_dup_we", 64'(we_cnt - snap_we), 64'd1);
        chk("t6_no_dup_re", 64'(re_cnt - snap_re), 64'd0);
        chk("t6_idle_busy", 64'(busy),             64'd0);

        // D-side readback of the written word
        snap();
        d_we  = 1'b0;
        d_req = 1'b1;
        serve(1'b1, 1'b0, 6, "t2rb");
        chk("t2rb_value", 64'(d_rd_data), 64'hCAFE_F00D);
        tick();
        d_req = 1'b0;
        tick();

        // Two collisions in a row: grant order follows the arbitration rule
        for (int k = 0; k < 2; k++) begin
            first = model_pick_d(1'b1, 1'b1);
            snap();
            i_addr = 16'h0010;
            d_addr = 16'h0200;
            d_we   = 1'b0;
            i_req  = 1'b1;
            d_req  = 1'b1;
            serve(first, 1'b0, 6, "t3_first");
            tick();
            if (first) d_req = 1'b0;
            else       i_req = 1'b0;
            snap();
            serve(!first, 1'b0, 6, "t3_second");
            tick();
            if (first) i_req = 1'b0;
            else       d_req = 1'b0;
            tick();
        end

        // Memory never answers: abort after TMO wait cycles
        chk("t4_tmo_before", 64'(timeout_err), 64'd0);
        mem_dead = 1'b1;
        snap();
        i_addr = 16'h0010;
        i_req  = 1'b1;
        serve(1'b0, 1'b1, int'(TMO) + 2, "t4");
        tick();
        i_req    = 1'b0;
        mem_dead = 1'b0;
        tick();
        snap();
        d_addr = 16'h0003;
        d_we   = 1'b0;
        d_req  = 1'b1;
        serve(1'b1, 1'b0, 6, "t4_sticky");
        tick();
        d_req = 1'b0;
        tick();

        // Reset while waiting on memory
        snap();
        i_addr = 16'h0010;
        i_req  = 1'b1;
        repeat (3) tick();
        rst   = 1'b1;
        i_req = 1'b0;
        tick();
        chk_reset_outputs("t5_rst");
        rst      = 1'b0;
        exp_i    = '0;
        exp_d    = '0;
        exp_tmo  = 1'b0;
        last_d_m = 1'b0;
        seen     = 1'b0;
        repeat (8) begin
            tick();
            if (i_rdy || d_rdy) seen = 1'b1;
        end
        chk("t5_no_rdy", 64'(seen), 64'd0);
        snap();
        i_req = 1'b1;
        serve(1'b0, 1'b0, 6, "t5_new");
        tick();
        i_req = 1'b0;
        tick();

        // Randomized traffic with random memory latency
        for (int n = 0; n < 40; n++) begin
            ri = 1'($urandom_range(0, 1));
            rq = 1'($urandom_range(0, 1));
            if (!ri && !rq) rq = 1'b1;
            i_addr  = AW'($urandom_range(0, 7));
            d_addr  = AW'($urandom_range(0, 7));
            d_we    = 1'($urandom_range(0, 1));
            d_wdata = $urandom;
            mem_lat = int'($urandom_range(2, 8));
            first   = model_pick_d(ri, rq);
            snap();
            i_req = ri;
            d_req = rq;
            serve(first, 1'b0, mem_lat + 2, "rnd_a");
            tick();
            if (first) d_req = 1'b0;
            else       i_req = 1'b0;
            if (ri && rq) begin
                snap();
                serve(!first, 1'b0, mem_lat + 2, "rnd_b");
                tick();
                if (first) i_req = 1'b0;
                else       d_req = 1'b0;
            end
            tick();
            chk("rnd_idle_busy", 64'(busy), 64'd0);
        end

        chk("never_re_and_we", 64'(both_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
